// File: rtl/tinyalu_core.sv
// TinyALU responder: captures A/B/op on start, add/and/xor complete in one cycle,
// mul completes MUL_LATENCY cycles after capture. done is a registered one-cycle pulse.
module tinyalu_core #(
   parameter int unsigned MUL_LATENCY = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  A,
   input  logic [7:0]  B,
   input  logic [2:0]  op,
   input  logic        start,
   output logic        done,
   output logic [15:0] result,
   output logic        busy,
   output logic        err_op
);

   typedef enum logic [1:0] {IDLE, EXEC, MUL, REARM} state_t;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [3:0] CNT_LAST = 4'(MUL_LATENCY);

   if (MUL_LATENCY < 2 || MUL_LATENCY > 8) begin : g_bad_latency
      $error("tinyalu_core: MUL_LATENCY must be within 2..8");
   end

   state_t      state_q, state_d;
   logic [7:0]  a_q, a_d, b_q, b_d;
   logic [2:0]  op_q, op_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        done_q, done_d;
   logic [15:0] result_q, result_d;
   logic        err_q, err_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= OP_NOP;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

   // Dropping start before the done edge aborts the command back to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (op == OP_ADD || op == OP_AND || op == OP_XOR) state_d = EXEC;
               else if (op == OP_MUL)                              state_d = MUL;
            end
         end
         EXEC:    state_d = start ? REARM : IDLE;
         MUL: begin
            if (!start)                 state_d = IDLE;
            else if (cnt_q == CNT_LAST) state_d = REARM;
         end
         REARM:   if (!start) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      result_d = result_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (op >= OP_ADD && op <= OP_MUL) begin
                  a_d   = A;
                  b_d   = B;
                  op_d  = op;
                  cnt_d = 4'd1;
               end else if (op != OP_NOP) begin
                  err_d = 1'b1;
               end
            end
         end
         EXEC: begin
            if (start) begin
               done_d = 1'b1;
               case (op_q)
                  OP_ADD:  result_d = {7'b0, {1'b0, a_q} + {1'b0, b_q}};
                  OP_AND:  result_d = {8'b0, a_q & b_q};
                  OP_XOR:  result_d = {8'b0, a_q ^ b_q};
                  default: result_d = result_q;
               endcase
            end
         end
         MUL: begin
            cnt_d = cnt_q + 4'd1;
            if (start && cnt_q == CNT_LAST) begin
               done_d   = 1'b1;
               result_d = {8'b0, a_q} * {8'b0, b_q};
            end
         end
         default: ;
      endcase
   end

   assign done   = done_q;
   assign result = result_q;
   assign busy   = (state_q == EXEC) || (state_q == MUL);
   assign err_op = err_q;

endmodule

// File: tb/tb_tinyalu_core.sv
// Bench for tinyalu_core: directed vector table, hand-built abort/reset/error
// sequences, and randomized commands checked against an arithmetic model.
module tb_tinyalu_core;
   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  A, B;
   logic [2:0]  op;
   logic        start;
   logic        done;
   logic [15:0] result;
   logic        busy;
   logic        err_op;

   int pass_cnt = 0, total_cnt = 0;
   int done_cnt = 0, dbl_cnt = 0;
   logic prev_done = 1'b0;

   always #5 clk = ~clk;

   tinyalu_core #(.MUL_LATENCY(LAT)) dut (
      .clk(clk), .reset(reset), .A(A), .B(B), .op(op), .start(start),
      .done(done), .result(result), .busy(busy), .err_op(err_op)
   );

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (done && prev_done) dbl_cnt++;
      prev_done = done;
   end

   typedef struct {
      logic [2:0]  op;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs [7];

   function automatic logic [15:0] model_res(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
      int x, y;
      x = a; y = b;
      case (o)
         3'd1:    return 16'(x + y);
         3'd2:    return {8'b0, a & b};
         3'd3:    return {8'b0, a ^ b};
         3'd4:    return 16'(x * y);
         default: return 16'h0;
      endcase
   endfunction

   function automatic int model_lat(input logic [2:0] o);
      return (o == 3'd4) ? LAT : 1;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Issue one command, scramble inputs after capture, measure latency and busy.
   task automatic do_cmd(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input int hold, output logic [15:0] res, output int lat, output int bcnt);
      A = a; B = b; op = o; start = 1'b1;
      @(posedge clk);
      #1;
      A = 8'($urandom); B = 8'($urandom); op = 3'($urandom);
      lat = 0; bcnt = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (done) break;
         lat++;
         if (busy) bcnt++;
      end
      res = result;
      repeat (hold) step();
      start = 1'b0;
      step();
   endtask

   initial begin
      logic [15:0] r, res;
      logic [2:0]  o;
      logic [7:0]  a, b;
      int lat, bcnt, d;

      vecs[0] = '{3'd1, 8'hFF, 8'h01, 16'h0100, 1};
      vecs[1] = '{3'd4, 8'hFF, 8'hFF, 16'hFE01, LAT};
      vecs[2] = '{3'd2, 8'hF0, 8'h3C, 16'h0030, 1};
      vecs[3] = '{3'd3, 8'hAA, 8'h55, 16'h00FF, 1};
      vecs[4] = '{3'd1, 8'hFF, 8'hFF, 16'h01FE, 1};
      vecs[5] = '{3'd4, 8'h00, 8'hFF, 16'h0000, LAT};
      vecs[6] = '{3'd4, 8'h0F, 8'h11, 16'h00FF, LAT};

      reset = 1'b1; start = 1'b0; A = '0; B = '0; op = '0;
      repeat (3) step();
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_op, 0);
      reset = 1'b0;
      step();

      foreach (vecs[i]) begin
         d = done_cnt;
         do_cmd(vecs[i].op, vecs[i].a, vecs[i].b, (i == 1) ? 2 : 0, res, lat, bcnt);
         chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
         chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
         chk($sformatf("vec%0d_busy", i), bcnt, vecs[i].lat);
         chk($sformatf("vec%0d_done_count", i), done_cnt - d, 1);
      end
      chk("done_low_after", done, 0);

      // no_op: ignored entirely
      r = result; d = done_cnt;
      op = 3'd0; A = 8'h12; B = 8'h34; start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      chk("nop_no_done", done_cnt - d, 0);
      chk("nop_result", result, r);
      chk("nop_busy", busy, 0);

      // unused opcode: sticky error, no done
      op = 3'b101; start = 1'b1;
      step();
      start = 1'b0;
      repeat (2) step();
      chk("err_set", err_op, 1);
      chk("err_no_done", done_cnt - d, 0);
      do_cmd(3'd1, 8'h12, 8'h34, 0, res, lat, bcnt);
      chk("add_after_err", res, 16'h0046);
      chk("err_sticky", err_op, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("err_cleared", err_op, 0);
      chk("reset_clears_result", result, 0);

      // mul aborted by start falling before done
      do_cmd(3'd1, 8'h21, 8'h10, 0, res, lat, bcnt);
      r = result; d = done_cnt;
      A = 8'h07; B = 8'h09; op = 3'd4; start = 1'b1;
      @(posedge clk);
      #1;
      step();
      step();
      start = 1'b0;
      step();
      chk("abort_busy_drop", busy, 0);
      repeat (4) step();
      chk("abort_no_done", done_cnt - d, 0);
      chk("abort_result", result, r);

      // reset mid-mul
      d = done_cnt;
      A = 8'h0A; B = 8'h0B; op = 3'd4; start = 1'b1;
      @(posedge clk);
      #1;
      step();
      reset = 1'b1; start = 1'b0;
      step();
      chk("midrst_done", done, 0);
      chk("midrst_result", result, 0);
      chk("midrst_busy", busy, 0);
      reset = 1'b0;
      repeat (LAT + 1) step();
      chk("midrst_no_done", done_cnt - d, 0);
      do_cmd(3'd1, 8'h05, 8'h06, 0, res, lat, bcnt);
      chk("post_rst_add", res, 16'h000B);
      chk("post_rst_lat", lat, 1);

      for (int i = 0; i < 40; i++) begin
         o = 3'($urandom_range(1, 4));
         a = 8'($urandom);
         b = 8'($urandom);
         d = done_cnt;
         do_cmd(o, a, b, $urandom_range(0, 2), res, lat, bcnt);
         chk($sformatf("rnd%0d_result op=%0d a=%0h b=%0h", i, o, a, b), res, model_res(o, a, b));
         chk($sformatf("rnd%0d_latency", i), lat, model_lat(o));
         chk($sformatf("rnd%0d_done_count", i), done_cnt - d, 1);
      end

      chk("done_single_cycle", dbl_cnt, 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
